// File: rtl/sm_als_responder_pkg.sv
// Shared constants and state encoding for the ALS SPI responder and its matrix-side master.
package sm_als_responder_pkg;

  localparam int SM_ALS_DATA_WIDTH  = 8;
  localparam int SM_ALS_LEAD_ZEROS  = 3;
  localparam int SM_ALS_FRAME_BITS  = 16;
  localparam int SM_ALS_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } als_state_t;

endpackage

// File: rtl/sm_sync_rst.sv
// Multi-stage synchroniser with a synchronous reset to a configurable idle level.
module sm_sync_rst #(
  parameter int              SIZE      = 1,
  parameter int              STAGES    = 2,
  parameter logic [SIZE-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/sm_als_responder.sv
// SPI responder emulating an ADC081S021-style ALS: shifts {lead zeros, sample, trail zeros} MSB first.
module sm_als_responder
  import sm_als_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = SM_ALS_DATA_WIDTH,
  parameter int LEAD_ZEROS  = SM_ALS_LEAD_ZEROS,
  parameter int FRAME_BITS  = SM_ALS_FRAME_BITS,
  parameter int SYNC_STAGES = SM_ALS_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sampleIn,
  input  logic                  sampleWe,
  input  logic                  alsCS,
  input  logic                  alsSCK,
  output logic                  alsSDO,
  output logic                  busy,
  output logic                  frameDone,
  output logic                  frameError,
  output logic [15:0]           frameCnt
);

  localparam int TRAIL = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;
  localparam int CW    = $clog2(FRAME_BITS + 1);
  localparam int IW    = $clog2(FRAME_BITS);

  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DATA_WIDTH-1:0] s);
    return FRAME_BITS'(s) << TRAIL;
  endfunction

  logic                  cs_s, sck_s, cs_q, sck_q;
  logic                  cs_fall, cs_rise, sck_fall, sck_rise;
  logic [DATA_WIDTH-1:0] holding, shadow, load_val;
  logic [FRAME_BITS-1:0] frame, load_frame;
  logic [CW-1:0]         rise_cnt;
  logic [IW-1:0]         bit_idx;
  als_state_t            state;

  // CS idles at 0 after reset so a frame needs a visible high-to-low transition.
  sm_sync_rst #(.SIZE(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
    .clk(clk), .rst(rst), .d(alsCS), .q(cs_s)
  );

  sm_sync_rst #(.SIZE(1), .STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sck_sync (
    .clk(clk), .rst(rst), .d(alsSCK), .q(sck_s)
  );

  assign cs_fall  = cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;
  assign sck_fall = sck_q & ~sck_s;
  assign sck_rise = ~sck_q & sck_s;

  assign load_val   = sampleWe ? sampleIn : holding;
  assign load_frame = frame_of(load_val);
  assign frame      = frame_of(shadow);
  assign bit_idx    = IW'(FRAME_BITS - 1) - rise_cnt[IW-1:0];
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q       <= 1'b0;
      sck_q      <= 1'b1;
      holding    <= '0;
      shadow     <= '0;
      rise_cnt   <= '0;
      state      <= IDLE;
      alsSDO     <= 1'b0;
      frameDone  <= 1'b0;
      frameError <= 1'b0;
      frameCnt   <= '0;
    end else begin
      cs_q       <= cs_s;
      sck_q      <= sck_s;
      frameDone  <= 1'b0;
      frameError <= 1'b0;
      if (sampleWe) holding <= sampleIn;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            shadow   <= load_val;
            rise_cnt <= '0;
            alsSDO   <= load_frame[FRAME_BITS-1];
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            frameError <= 1'b1;
            alsSDO     <= 1'b0;
            state      <= IDLE;
          end else if (sck_rise) begin
            rise_cnt <= rise_cnt + 1'b1;
            if (rise_cnt == CW'(FRAME_BITS - 1)) state <= DONE;
          end else if (sck_fall && rise_cnt != '0) begin
            // The first fall after CS precedes any rise; bit 0 was already presented at CS fall.
            alsSDO <= frame[bit_idx];
          end
        end
        DONE: begin
          if (cs_rise) begin
            frameDone <= 1'b1;
            frameCnt  <= frameCnt + 16'd1;
            alsSDO    <= 1'b0;
            state     <= IDLE;
          end else if (sck_rise || sck_fall) begin
            alsSDO <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm_als_responder.sv
// Directed bench: an SPI master model clocks frames out of the responder and checks them via a scoreboard.
module tb_sm_als_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sampleIn = 8'h00;
  logic        sampleWe = 1'b0;
  logic        alsCS = 1'b1;
  logic        alsSCK = 1'b1;
  logic        alsSDO, busy, frameDone, frameError;
  logic [15:0] frameCnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [7:0]  hold_model = 8'h00;
  logic [15:0] exp_cnt = 16'h0000;
  logic [31:0] sb_q [$];

  sm_als_responder dut (
    .clk(clk), .rst(rst), .sampleIn(sampleIn), .sampleWe(sampleWe),
    .alsCS(alsCS), .alsSCK(alsSCK), .alsSDO(alsSDO), .busy(busy),
    .frameDone(frameDone), .frameError(frameError), .frameCnt(frameCnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frameDone)  done_cnt++;
    if (frameError) err_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected serial word for an n-bit read of sample s: zeros pad past the 16-bit frame.
  function automatic logic [31:0] exp_word(input logic [7:0] s, input int nbits);
    logic [31:0] w;
    w = {16'h0000, 3'b000, s, 5'b00000};
    if (nbits <= 16) return w >> (16 - nbits);
    return w << (nbits - 16);
  endfunction

  task automatic run_frame(input string tag, input int nbits, input int we_bit,
                           input logic [7:0] we_val, input int rst_bit);
    logic [31:0] cap;
    logic [31:0] exp;
    int          d0, e0;
    bit          aborted;
    cap     = '0;
    d0      = done_cnt;
    e0      = err_cnt;
    aborted = 1'b0;
    if (rst_bit < 0) sb_q.push_back(exp_word(hold_model, nbits));
    alsCS = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      alsSCK = 1'b0;
      if (i == we_bit) begin
        sampleIn = we_val;
        sampleWe = 1'b1;
        hold_model = we_val;
        wait_clk(1);
        sampleWe = 1'b0;
        wait_clk(7);
      end else begin
        wait_clk(8);
      end
      alsSCK = 1'b1;
      cap = {cap[30:0], alsSDO};
      if (i == rst_bit) begin
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        aborted = 1'b1;
        hold_model = 8'h00;
        exp_cnt = 16'h0000;
        wait_clk(1);
        chk({tag, " sdo after rst"}, {31'd0, alsSDO}, 32'd0);
        chk({tag, " busy after rst"}, {31'd0, busy}, 32'd0);
        chk({tag, " cnt after rst"}, {16'd0, frameCnt}, 32'd0);
        wait_clk(4);
      end else begin
        wait_clk(8);
      end
      if (aborted && i > rst_bit)
        chk({tag, " idle while cs low"}, {30'd0, busy, alsSDO}, 32'd0);
    end
    wait_clk(8);
    if (!aborted) begin
      chk({tag, " busy before cs rise"}, {31'd0, busy}, 32'd1);
      chk({tag, " no early done"}, done_cnt, d0);
    end
    alsCS = 1'b1;
    wait_clk(8);
    if (!aborted) begin
      exp = sb_q.pop_front();
      chk({tag, " data"}, cap, exp);
      if (nbits < 16) begin
        chk({tag, " error pulse"}, err_cnt, e0 + 1);
        chk({tag, " done pulse"}, done_cnt, d0);
      end else begin
        exp_cnt = exp_cnt + 16'd1;
        chk({tag, " done pulse"}, done_cnt, d0 + 1);
        chk({tag, " error pulse"}, err_cnt, e0);
      end
    end else begin
      chk({tag, " no done"}, done_cnt, d0);
      chk({tag, " no error"}, err_cnt, e0);
    end
    chk({tag, " frameCnt"}, {16'd0, frameCnt}, {16'd0, exp_cnt});
    chk({tag, " sdo idle"}, {31'd0, alsSDO}, 32'd0);
  endtask

  initial begin
    // Reset and idle behaviour.
    wait_clk(3);
    rst = 1'b0;
    wait_clk(1);
    chk("reset sdo", {31'd0, alsSDO}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset cnt", {16'd0, frameCnt}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      alsSCK = 1'b0;
      wait_clk(8);
      alsSCK = 1'b1;
      wait_clk(8);
    end
    chk("idle sck busy", {31'd0, busy}, 32'd0);
    chk("idle sck sdo", {31'd0, alsSDO}, 32'd0);
    chk("idle sck pulses", done_cnt + err_cnt, 0);

    sampleIn = 8'hA5;
    sampleWe = 1'b1;
    hold_model = 8'hA5;
    wait_clk(1);
    sampleWe = 1'b0;
    wait_clk(4);

    run_frame("full A5", 16, -1, 8'h00, -1);
    run_frame("short 7", 7, -1, 8'h00, -1);
    run_frame("after err", 16, -1, 8'h00, -1);
    run_frame("midwrite", 16, 6, 8'h3C, -1);
    run_frame("next 3C", 16, -1, 8'h00, -1);
    run_frame("long 20", 20, -1, 8'h00, -1);
    run_frame("rst bit5", 16, -1, 8'h00, 5);
    run_frame("post rst", 16, -1, 8'h00, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
